vga_cell_timing: RTL and testbench
==================================

# vga_cell_timing

Pixel-timing and character-cell generator for the 640×480@60 glyph-mode display, running on the 25.175 MHz pixel clock. Sits directly upstream of the glyph renderer: produces sync, blanking, raw pixel position, decoded 8-pixel-wide × 12-line cell coordinates (replacing the divide-by-3 ROM path), and a clock-domain frame counter. The frame counter replaces any logic clocked from vsync.

## Interface

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BACK, 33, vertical back porch
- CELL_H, 12, glyph lines per cell row; must be ≤ 16

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; synchronous, active-low
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- display_on  out  1  high inside the visible 640×480 area
- hpos  out  10  pixel column, 0..799
- vpos  out  10  line, 0..524
- cell_x  out  7  hpos[9:3]
- glyph_x  out  3  hpos[2:0]
- cell_y  out  6  vpos / CELL_H
- glyph_y  out  4  vpos % CELL_H
- frame  out  11  frame counter
- frame_tick  out  1  one-cycle pulse on frame increment

## Operation

- All outputs are registered and mutually consistent. On any cycle, every output describes the same (hpos, vpos).
- hpos increments each clock. It wraps from H_TOTAL−1 (799) to 0. On that wrap, vpos increments. vpos wraps from V_TOTAL−1 (524) to 0.
- Decode flags are computed from the next-state counters, so they carry no extra lag relative to hpos/vpos:
  - hsync = 0 iff hpos ∈ [656, 751].
  - vsync = 0 iff vpos ∈ [490, 491].
  - display_on = (hpos < 640) && (vpos < 480).
- Cell-column decode: cell_x and glyph_x are direct bit slices of registered hpos.
- Cell-row decode uses incremental counters; no divider.
  - At each hpos wrap, glyph_y increments.
  - When glyph_y is at CELL_H−1, glyph_y goes to 0 and cell_y increments.
  - When vpos wraps to 0, cell_y and glyph_y both go to 0, overriding the increment.
  - Invariant: cell_y = vpos / 12 and glyph_y = vpos % 12 on every line, including blanking.
  - Last line: vpos 524 gives cell_y 43, glyph_y 8.
- Frame counter:
  - frame increments on the edge where (hpos, vpos) goes (799, 489) → (0, 490), i.e. entry into vsync.
  - frame wraps 2047 → 0.
  - frame_tick is high for exactly the one cycle at (0, 490). frame already shows the new value in that cycle.

## Timing

- Line length: 800 clocks.
- Frame length: 525 lines, i.e. 420 000 clocks.
- Latency: every output changes one clock edge after the corresponding counter state is reached. There is no other pipeline delay.
- Reset values (rst_n sampled low at an edge):
  - hpos 0, vpos 0
  - cell_x 0, glyph_x 0, cell_y 0, glyph_y 0
  - frame 0, frame_tick 0
  - hsync 1, vsync 1, display_on 1 (the decode of (0, 0))
- First edge with rst_n high gives hpos 1.
- Reset mid-line or mid-frame: takes effect at the next edge with no partial-line completion. frame returns to 0 and no frame_tick is issued.
- Simultaneous events:
  - At (799, 524), the hpos, vpos, cell and glyph wraps all occur on the same edge.
  - The cell-row reset has priority over the CELL_H wrap.

## Configuration

- Macro: VGA_CELL_TIMING_FRAME_EN.
- Defined: frame counter and frame_tick are implemented as described above.
- Undefined:
  - frame is tied to 0 and frame_tick is tied to 0.
  - No frame-counter flops are synthesised.
  - All other outputs are unchanged.

## Test plan

- Reset check: hold rst_n low 3 cycles, then release.
  - While low: all outputs at the reset values above.
  - First cycle after release: hpos=1, display_on=1.
- Horizontal timing:
  - hsync falls at hpos=656 and rises at hpos=752, i.e. 96 cycles low.
  - display_on falls at hpos=640.
  - Line period is exactly 800 clocks.
- Cell rows:
  - vpos=11: glyph_y=11, cell_y=0.
  - vpos=12: glyph_y=0, cell_y=1.
  - vpos=479: cell_y=39, glyph_y=11.
  - vpos=480: cell_y=40, glyph_y=0, display_on=0.
  - vpos=524: cell_y=43, glyph_y=8.
  - Next line: all zero.
- Frame behaviour: run 3 full frames (1 260 000 clocks).
  - Exactly 3 frame_tick pulses, each at (0, 490) and each 420 000 clocks apart.
  - frame reads 1, 2, 3; vsync is low for 1600 clocks per frame.
- Mid-frame reset: pulse rst_n low for one edge at (300, 200) during frame 5.
  - Outputs return to reset values, then resume from hpos 1.
  - frame=0, and the next frame_tick occurs 490×800 clocks later.
- Macro off: build without VGA_CELL_TIMING_FRAME_EN and run 2 frames.
  - frame=0 and frame_tick=0 throughout.
  - Sync and cell outputs are identical to the macro-on build.

Source files
------------

// File: rtl/vga_cell_timing.sv
// vga_cell_timing: 640x480@60 sync, pixel position and 8x12 character-cell generator.
// Frame counter and frame_tick exist only when VGA_CELL_TIMING_FRAME_EN is defined.
module vga_cell_timing #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CELL_H    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        hsync,
  output logic        vsync,
  output logic        display_on,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic [6:0]  cell_x,
  output logic [2:0]  glyph_x,
  output logic [5:0]  cell_y,
  output logic [3:0]  glyph_y,
  output logic [10:0] frame,
  output logic        frame_tick
);
  localparam logic [9:0] H_MAX  = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX  = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_ON  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_OFF = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_OFF = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [3:0] GY_MAX = 4'(CELL_H - 1);
  logic       h_last, v_last, g_last;
  logic [9:0] h_nxt, v_nxt;
  logic [5:0] cy_nxt;
  logic [3:0] gy_nxt;
  // Flags decode the next-state counters so they line up with registered hpos/vpos.
  always_comb begin
    h_last = hpos == H_MAX;
    v_last = vpos == V_MAX;
    g_last = glyph_y == GY_MAX;
    h_nxt  = h_last ? 10'd0 : hpos + 10'd1;
    v_nxt  = h_last ? (v_last ? 10'd0 : vpos + 10'd1) : vpos;
    gy_nxt = h_last ? ((v_last || g_last) ? 4'd0 : glyph_y + 4'd1) : glyph_y;
    cy_nxt = h_last ? (v_last ? 6'd0 : (g_last ? cell_y + 6'd1 : cell_y)) : cell_y;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos       <= '0;
      vpos       <= '0;
      cell_y     <= '0;
      glyph_y    <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      display_on <= 1'b1;
    end else begin
      hpos       <= h_nxt;
      vpos       <= v_nxt;
      cell_y     <= cy_nxt;
      glyph_y    <= gy_nxt;
      hsync      <= !(h_nxt >= HS_ON && h_nxt < HS_OFF);
      vsync      <= !(v_nxt >= VS_ON && v_nxt < VS_OFF);
      display_on <= h_nxt < H_VIS && v_nxt < V_VIS;
    end
  end
  assign cell_x  = hpos[9:3];
  assign glyph_x = hpos[2:0];
`ifdef VGA_CELL_TIMING_FRAME_EN
  logic tick_nxt;
  // Counts entries into vsync, i.e. the wrap into line VS_ON.
  assign tick_nxt = h_last && vpos == VS_ON - 10'd1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame      <= frame + 11'(tick_nxt);
      frame_tick <= tick_nxt;
    end
  end
`else
  assign frame      = '0;
  assign frame_tick = 1'b0;
`endif
endmodule

// File: tb/tb_vga_cell_timing.sv
// tb_vga_cell_timing: scoreboard bench; dut_a uses the 640x480 timing, dut_b a 24-clock line
// so that whole 525-line frames fit in a short run.
module tb_vga_cell_timing;
`ifdef VGA_CELL_TIMING_FRAME_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif
  localparam int R = 3;
  localparam int C = 42613;
  localparam int END_CYC = 54380;

  typedef struct {
    int cyc, hp, vp, hs, vs, de, cx, gx, cy, gy, fr, tk;
  } vec_t;

  logic clk = 1'b0, rst_a = 1'b0, rst_b = 1'b0;
  logic a_hs, a_vs, a_de, a_tk, b_hs, b_vs, b_de, b_tk;
  logic [9:0] a_hp, a_vp, b_hp, b_vp;
  logic [6:0] a_cx, b_cx;
  logic [2:0] a_gx, b_gx;
  logic [5:0] a_cy, b_cy;
  logic [3:0] a_gy, b_gy;
  logic [10:0] a_fr, b_fr;
  int cyc = 0, checks = 0, errors = 0, vs_lo = 0;
  vec_t qa[$], qb[$];
  int tq[$], tfq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_cell_timing dut_a (
    .clk(clk), .rst_n(rst_a), .hsync(a_hs), .vsync(a_vs), .display_on(a_de),
    .hpos(a_hp), .vpos(a_vp), .cell_x(a_cx), .glyph_x(a_gx), .cell_y(a_cy),
    .glyph_y(a_gy), .frame(a_fr), .frame_tick(a_tk)
  );

  vga_cell_timing #(.H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2)) dut_b (
    .clk(clk), .rst_n(rst_b), .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
    .hpos(b_hp), .vpos(b_vp), .cell_x(b_cx), .glyph_x(b_gx), .cell_y(b_cy),
    .glyph_y(b_gy), .frame(b_fr), .frame_tick(b_tk)
  );

  task automatic chk(input string nm, input int c, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, c, got, exp);
    end
  endtask

  task automatic push(input bit b, input int c, input int hp, input int vp, input int hs,
                      input int vs, input int de, input int cy, input int gy, input int fr,
                      input int tk);
    vec_t v;
    logic [9:0] h;
    h = 10'(hp);
    v.cyc = c; v.hp = hp; v.vp = vp; v.hs = hs; v.vs = vs; v.de = de;
    v.cx = int'(h[9:3]); v.gx = int'(h[2:0]); v.cy = cy; v.gy = gy;
    v.fr = FEN ? fr : 0; v.tk = FEN ? tk : 0;
    if (b) qb.push_back(v);
    else qa.push_back(v);
    if (b && FEN && tk != 0) begin
      tq.push_back(c);
      tfq.push_back(fr);
    end
  endtask

  task automatic cmp(input string d, input vec_t e, input vec_t a);
    chk({d, " sched"}, cyc, a.cyc, e.cyc);
    chk({d, " hpos"}, e.cyc, a.hp, e.hp);
    chk({d, " vpos"}, e.cyc, a.vp, e.vp);
    chk({d, " hsync"}, e.cyc, a.hs, e.hs);
    chk({d, " vsync"}, e.cyc, a.vs, e.vs);
    chk({d, " display_on"}, e.cyc, a.de, e.de);
    chk({d, " cell_x"}, e.cyc, a.cx, e.cx);
    chk({d, " glyph_x"}, e.cyc, a.gx, e.gx);
    chk({d, " cell_y"}, e.cyc, a.cy, e.cy);
    chk({d, " glyph_y"}, e.cyc, a.gy, e.gy);
    chk({d, " frame"}, e.cyc, a.fr, e.fr);
    chk({d, " frame_tick"}, e.cyc, a.tk, e.tk);
  endtask

  function automatic vec_t obs(input bit b);
    vec_t v;
    v.cyc = cyc;
    v.hp = b ? int'(b_hp) : int'(a_hp);
    v.vp = b ? int'(b_vp) : int'(a_vp);
    v.hs = b ? int'(b_hs) : int'(a_hs);
    v.vs = b ? int'(b_vs) : int'(a_vs);
    v.de = b ? int'(b_de) : int'(a_de);
    v.cx = b ? int'(b_cx) : int'(a_cx);
    v.gx = b ? int'(b_gx) : int'(a_gx);
    v.cy = b ? int'(b_cy) : int'(a_cy);
    v.gy = b ? int'(b_gy) : int'(a_gy);
    v.fr = b ? int'(b_fr) : int'(a_fr);
    v.tk = b ? int'(b_tk) : int'(a_tk);
    return v;
  endfunction

  // Monitor: pops whichever expectations fall due this cycle, and every frame_tick pulse.
  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].cyc <= cyc) cmp("A", qa.pop_front(), obs(1'b0));
    while (qb.size() > 0 && qb[0].cyc <= cyc) cmp("B", qb.pop_front(), obs(1'b1));
    if (cyc < C && !b_vs) vs_lo++;
    if (b_tk) begin
      if (tq.size() == 0) chk("B unexpected frame_tick", cyc, 1, 0);
      else begin
        chk("B tick cycle", cyc, cyc, tq.pop_front());
        chk("B tick frame", cyc, int'(b_fr), tfq.pop_front());
      end
    end
    if (a_tk) chk("A unexpected frame_tick", cyc, 1, 0);
  end

  initial begin
    push(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    push(0, 2, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    push(0, R, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    push(0, R + 1, 1, 0, 1, 1, 1, 0, 0, 0, 0);
    push(0, R + 639, 639, 0, 1, 1, 1, 0, 0, 0, 0);
    push(0, R + 640, 640, 0, 1, 1, 0, 0, 0, 0, 0);
    push(0, R + 655, 655, 0, 1, 1, 0, 0, 0, 0, 0);
    push(0, R + 656, 656, 0, 0, 1, 0, 0, 0, 0, 0);
    push(0, R + 751, 751, 0, 0, 1, 0, 0, 0, 0, 0);
    push(0, R + 752, 752, 0, 1, 1, 0, 0, 0, 0, 0);
    push(0, R + 799, 799, 0, 1, 1, 0, 0, 0, 0, 0);
    push(0, R + 800, 0, 1, 1, 1, 1, 0, 1, 0, 0);
    push(0, R + 8800, 0, 11, 1, 1, 1, 0, 11, 0, 0);
    push(0, R + 9600, 0, 12, 1, 1, 1, 1, 0, 0, 0);

    push(1, 2, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    push(1, R, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    push(1, R + 1, 1, 0, 1, 1, 1, 0, 0, 0, 0);
    push(1, R + 17, 17, 0, 1, 1, 0, 0, 0, 0, 0);
    push(1, R + 18, 18, 0, 0, 1, 0, 0, 0, 0, 0);
    push(1, R + 21, 21, 0, 0, 1, 0, 0, 0, 0, 0);
    push(1, R + 22, 22, 0, 1, 1, 0, 0, 0, 0, 0);
    push(1, R + 264, 0, 11, 1, 1, 1, 0, 11, 0, 0);
    push(1, R + 288, 0, 12, 1, 1, 1, 1, 0, 0, 0);
    push(1, R + 11496, 0, 479, 1, 1, 1, 39, 11, 0, 0);
    push(1, R + 11520, 0, 480, 1, 1, 0, 40, 0, 0, 0);
    push(1, R + 11759, 23, 489, 1, 1, 0, 40, 9, 0, 0);
    push(1, R + 11760, 0, 490, 1, 0, 0, 40, 10, 1, 1);
    push(1, R + 11761, 1, 490, 1, 0, 0, 40, 10, 1, 0);
    push(1, R + 11807, 23, 491, 1, 0, 0, 40, 11, 1, 0);
    push(1, R + 11808, 0, 492, 1, 1, 0, 41, 0, 1, 0);
    push(1, R + 12599, 23, 524, 1, 1, 0, 43, 8, 1, 0);
    push(1, R + 12600, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    push(1, R + 24360, 0, 490, 1, 0, 0, 40, 10, 2, 1);
    push(1, R + 36960, 0, 490, 1, 0, 0, 40, 10, 3, 1);
    push(1, C, 10, 200, 1, 1, 1, 16, 8, 3, 0);
    push(1, C + 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    push(1, C + 2, 1, 0, 1, 1, 1, 0, 0, 0, 0);
    push(1, C + 1 + 11760, 0, 490, 1, 0, 0, 40, 10, 1, 1);

    repeat (R) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    while (cyc < C) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    while (cyc < END_CYC) @(negedge clk);
    chk("A pending vectors", cyc, qa.size(), 0);
    chk("B pending vectors", cyc, qb.size(), 0);
    chk("B missing frame_tick", cyc, tq.size(), 0);
    chk("B vsync low clocks", cyc, vs_lo, 3 * 48);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
